// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared types and constants for the RTC capture bank
package rtc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_SKIP,
        S_CAPT,
        S_COMMIT,
        S_DONE
    } state_t;

    localparam logic [6:0] ASCII_ZERO    = 7'h30;
    localparam logic [6:0] ASCII_ERR_DEF = 7'h3F;

    localparam int F_SEC  = 0;
    localparam int F_MIN  = 1;
    localparam int F_HR   = 2;
    localparam int F_DATE = 3;
    localparam int F_MON  = 4;
    localparam int F_YR   = 5;
    localparam int F_DOW  = 6;
    localparam int F_WEEK = 7;
    localparam int F_TSEC = 8;
    localparam int F_TMIN = 9;
    localparam int F_THR  = 10;

endpackage

// File: rtl/rtc_bin2ascii.sv
// rtl/rtc_bin2ascii.sv - combinational byte to two-ASCII-digit decoder (binary or packed BCD)
module rtc_bin2ascii
    import rtc_pkg::*;
#(
    parameter logic [6:0] ASCII_ERR = ASCII_ERR_DEF
) (
    input  logic [7:0] data_in,
    input  logic       mode,
    output logic [6:0] tens,
    output logic [6:0] units
);

    logic [6:0] rem;
    logic [3:0] tdig;

    // Restoring compare-subtract chain for /10 and %10; only meaningful for inputs <= 99
    always_comb begin
        rem  = data_in[6:0];
        tdig = 4'd0;
        if (rem >= 7'd80) begin rem = rem - 7'd80; tdig = tdig + 4'd8; end
        if (rem >= 7'd40) begin rem = rem - 7'd40; tdig = tdig + 4'd4; end
        if (rem >= 7'd20) begin rem = rem - 7'd20; tdig = tdig + 4'd2; end
        if (rem >= 7'd10) begin rem = rem - 7'd10; tdig = tdig + 4'd1; end
    end

    always_comb begin
        tens  = ASCII_ERR;
        units = ASCII_ERR;
        if (mode) begin
            if (data_in[7:4] <= 4'd9) tens  = ASCII_ZERO + {3'b000, data_in[7:4]};
            if (data_in[3:0] <= 4'd9) units = ASCII_ZERO + {3'b000, data_in[3:0]};
        end else if (data_in <= 8'd99) begin
            tens  = ASCII_ZERO + {3'b000, tdig};
            units = ASCII_ZERO + rem;
        end
    end

endmodule

// File: rtl/rtc_capture_bank.sv
// rtl/rtc_capture_bank.sv - per-blanking RTC sequence capture with shadow/display banks and registered read port
module rtc_capture_bank
    import rtc_pkg::*;
#(
    parameter int         NUM_FIELDS = 11,
    parameter int         SKIP_BYTES = 4,
    parameter int         INPUT_BCD  = 0,
    parameter logic [6:0] ASCII_ERR  = 7'h3F,
    parameter int         IDX_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             blank,
    input  logic             seq_start,
    input  logic             data_valid,
    input  logic [7:0]       data_in,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [6:0]       rd_tens,
    output logic [6:0]       rd_units,
    output logic             commit,
    output logic             busy,
    output logic             abort_err
);

    state_t           state, state_nxt;
    logic             blank_q;
    logic [7:0]       skip_cnt, cnt_eff;
    logic [IDX_W-1:0] ptr, ptr_eff;
    logic [13:0]      shadow  [NUM_FIELDS];
    logic [13:0]      display [NUM_FIELDS];
    logic [6:0]       dec_tens, dec_units;
    logic             in_run, active, start, in_skip, in_capt;
    logic             skip_done, wr_shadow, last;

    rtc_bin2ascii #(.ASCII_ERR(ASCII_ERR)) u_dec (
        .data_in (data_in),
        .mode    (INPUT_BCD != 0),
        .tens    (dec_tens),
        .units   (dec_units)
    );

    // A seq_start folds into the current cycle as byte 0, so counters see "effective" values
    always_comb begin
        in_run    = (state == S_ARMED) || (state == S_SKIP) || (state == S_CAPT);
        active    = blank && in_run;
        start     = active && seq_start;
        in_skip   = active && (start ? (SKIP_BYTES != 0) : (state == S_SKIP));
        in_capt   = active && (start ? (SKIP_BYTES == 0) : (state == S_CAPT));
        cnt_eff   = start ? 8'd0 : skip_cnt;
        ptr_eff   = start ? '0 : ptr;
        skip_done = in_skip && data_valid && (cnt_eff == 8'(SKIP_BYTES - 1));
        wr_shadow = in_capt && data_valid;
        last      = wr_shadow && (ptr_eff == IDX_W'(NUM_FIELDS - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (blank && !blank_q) state_nxt = S_ARMED;
            S_ARMED, S_SKIP, S_CAPT: begin
                if (!blank)                      state_nxt = S_IDLE;
                else if (last)                   state_nxt = S_COMMIT;
                else if (skip_done || in_capt)   state_nxt = S_CAPT;
                else if (in_skip)                state_nxt = S_SKIP;
            end
            S_COMMIT: state_nxt = S_DONE;
            S_DONE:   if (!blank) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        commit = (state == S_COMMIT);
        busy   = (state == S_SKIP) || (state == S_CAPT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blank_q   <= 1'b0;
            skip_cnt  <= 8'd0;
            ptr       <= '0;
            abort_err <= 1'b0;
            rd_tens   <= ASCII_ZERO;
            rd_units  <= ASCII_ZERO;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                shadow[i]  <= {ASCII_ZERO, ASCII_ZERO};
                display[i] <= {ASCII_ZERO, ASCII_ZERO};
            end
        end else begin
            blank_q <= blank;
            if (in_skip) skip_cnt <= cnt_eff + {7'd0, data_valid};
            if (wr_shadow)               ptr <= ptr_eff + 1'b1;
            else if (skip_done || start) ptr <= '0;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                if (wr_shadow && (ptr_eff == IDX_W'(i))) shadow[i] <= {dec_tens, dec_units};
            end
            if (state == S_COMMIT) begin
                for (int i = 0; i < NUM_FIELDS; i++) display[i] <= shadow[i];
                abort_err <= 1'b0;
            end else if (busy && !blank) begin
                abort_err <= 1'b1;
            end
            rd_tens  <= ASCII_ERR;
            rd_units <= ASCII_ERR;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                if (rd_idx == IDX_W'(i)) begin
                    rd_tens  <= display[i][13:7];
                    rd_units <= display[i][6:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_rtc_capture_bank.sv
// tb/tb_rtc_capture_bank.sv - directed self-checking bench for rtc_capture_bank (binary and BCD instances)
module tb_rtc_capture_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       blank = 1'b0;
    logic       seq_start = 1'b0;
    logic       data_valid = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic [3:0] rd_idx = 4'd0;
    logic [6:0] rd_tens, rd_units, b_tens, b_units;
    logic       commit, busy, abort_err;
    logic       b_commit, b_busy, b_abort;

    int vectors = 0;
    int fails = 0;
    int commit_cnt = 0;
    logic [7:0] fb [11];

    localparam logic [13:0] ERR2 = {7'h3F, 7'h3F};

    rtc_capture_bank dut (
        .clk(clk), .reset(reset), .blank(blank), .seq_start(seq_start),
        .data_valid(data_valid), .data_in(data_in), .rd_idx(rd_idx),
        .rd_tens(rd_tens), .rd_units(rd_units), .commit(commit),
        .busy(busy), .abort_err(abort_err)
    );

    rtc_capture_bank #(.INPUT_BCD(1)) dut_bcd (
        .clk(clk), .reset(reset), .blank(blank), .seq_start(seq_start),
        .data_valid(data_valid), .data_in(data_in), .rd_idx(rd_idx),
        .rd_tens(b_tens), .rd_units(b_units), .commit(b_commit),
        .busy(b_busy), .abort_err(b_abort)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (commit) commit_cnt++;

    function automatic logic [13:0] asc(input int t, input int u);
        return {7'(8'h30 + t), 7'(8'h30 + u)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        data_valid = 1'b1;
        data_in    = b;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic read_field(input int idx);
        rd_idx = 4'(idx);
        tick();
    endtask

    task automatic skip_and_fields();
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
        for (int i = 0; i < 11; i++) send_byte(fb[i]);
        tick();
    endtask

    task automatic full_frame();
        blank = 1'b1;
        tick();
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        skip_and_fields();
    endtask

    task automatic end_interval();
        blank = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        tick();
        tick();
        check("reset_rd", {rd_tens, rd_units}, asc(0, 0));
        check("reset_flags", {commit, busy, abort_err}, 3'b000);
        reset = 1'b0;
        tick();

        // 1: basic binary frame
        fb = '{8'd59, 8'd7, 8'd23, 8'd15, 8'd6, 8'd24, 8'd3, 8'd12, 8'd30, 8'd45, 8'd11};
        full_frame();
        check("s1_commit_cnt", commit_cnt, 1);
        read_field(0); check("s1_f0", {rd_tens, rd_units}, asc(5, 9));
        read_field(1); check("s1_f1", {rd_tens, rd_units}, asc(0, 7));
        read_field(10); check("s1_f10", {rd_tens, rd_units}, asc(1, 1));
        end_interval();

        // 2: out-of-range and 99
        fb = '{8'd12, 8'd34, 8'd150, 8'd99, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
        full_frame();
        check("s2_commit_cnt", commit_cnt, 2);
        read_field(2); check("s2_f2_err", {rd_tens, rd_units}, ERR2);
        read_field(3); check("s2_f3_99", {rd_tens, rd_units}, asc(9, 9));
        read_field(1); check("s2_f1", {rd_tens, rd_units}, asc(3, 4));
        read_field(4); check("s2_f4_0", {rd_tens, rd_units}, asc(0, 0));
        read_field(11); check("s2_idx11", {rd_tens, rd_units}, ERR2);
        read_field(15); check("s2_idx15", {rd_tens, rd_units}, ERR2);
        end_interval();

        // 3: BCD instance alongside binary
        fb = '{8'h45, 8'h4C, 8'h99, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        full_frame();
        read_field(0);
        check("s3_bcd_f0", {b_tens, b_units}, asc(4, 5));
        check("s3_bin_f0", {rd_tens, rd_units}, asc(6, 9));
        read_field(1);
        check("s3_bcd_f1", {b_tens, b_units}, {7'h34, 7'h3F});
        check("s3_bin_f1", {rd_tens, rd_units}, asc(7, 6));
        read_field(2);
        check("s3_bcd_f2", {b_tens, b_units}, asc(9, 9));
        check("s3_bin_f2", {rd_tens, rd_units}, ERR2);
        end_interval();

        // 4: abort after 6 field bytes
        blank = 1'b1;
        tick();
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'hB0);
        for (int i = 0; i < 6; i++) send_byte(8'd88);
        check("s4_busy", busy, 1'b1);
        blank = 1'b0;
        tick();
        check("s4_abort", {abort_err, busy}, 2'b10);
        check("s4_commit_cnt", commit_cnt, 3);
        read_field(0); check("s4_f0_kept", {rd_tens, rd_units}, asc(6, 9));
        fb = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd91, 8'd92};
        full_frame();
        check("s4_abort_clr", abort_err, 1'b0);
        check("s4_commit_cnt2", commit_cnt, 4);
        read_field(5); check("s4_f5", {rd_tens, rd_units}, asc(6, 0));
        end_interval();

        // 5: restart inside an interval, ignored start in DONE, then another interval
        blank = 1'b1;
        tick();
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'hC0);
        send_byte(8'd77);
        send_byte(8'd77);
        seq_start = 1'b1;
        send_byte(8'hC1);
        seq_start = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(8'hC2);
        fb = '{8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29, 8'd31, 8'd32};
        for (int i = 0; i < 11; i++) send_byte(fb[i]);
        tick();
        check("s5_commit_once", commit_cnt, 5);
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        for (int i = 0; i < 15; i++) send_byte(8'd55);
        tick();
        check("s5_done_ignored", {commit_cnt[7:0], busy}, {8'd5, 1'b0});
        read_field(0); check("s5_f0", {rd_tens, rd_units}, asc(2, 1));
        read_field(1); check("s5_f1", {rd_tens, rd_units}, asc(2, 2));
        end_interval();
        fb = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11};
        full_frame();
        check("s5_second_interval", commit_cnt, 6);
        read_field(8); check("s5_f8", {rd_tens, rd_units}, asc(0, 9));
        end_interval();

        // 6: reset mid-capture
        blank = 1'b1;
        tick();
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'hD0);
        send_byte(8'd42);
        rd_idx = 4'd1;
        reset = 1'b1;
        blank = 1'b0;
        #1;
        check("s6_reset_rd", {rd_tens, rd_units}, asc(0, 0));
        check("s6_reset_busy", busy, 1'b0);
        tick();
        reset = 1'b0;
        read_field(8); check("s6_f8_cleared", {rd_tens, rd_units}, asc(0, 0));
        fb = '{8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88, 8'd98, 8'd97, 8'd96, 8'd95, 8'd94};
        full_frame();
        check("s6_commit_after_reset", commit_cnt, 7);
        read_field(10); check("s6_f10", {rd_tens, rd_units}, asc(9, 4));
        end_interval();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
